// File: rtl/ex_muldiv_pkg.sv
// Shared constants for the EX-stage iterative multiply/divide unit:
// op encodings, FSM state codes, iteration count and small op decoders.
package ex_muldiv_pkg;

    localparam logic [1:0] OP_MULT  = 2'b00;
    localparam logic [1:0] OP_MULTU = 2'b01;
    localparam logic [1:0] OP_DIV   = 2'b10;
    localparam logic [1:0] OP_DIVU  = 2'b11;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_FIX  = 2'd2;

    localparam int MULDIV_ITERS = 32;

    function automatic logic is_div_op(input logic [1:0] op);
        return (op == OP_DIV) || (op == OP_DIVU);
    endfunction

    function automatic logic is_signed_op(input logic [1:0] op);
        return (op == OP_MULT) || (op == OP_DIV);
    endfunction

    // Two's-complement magnitude; 32'h80000000 maps to itself, read as unsigned.
    function automatic logic [31:0] mag32(input logic [31:0] v, input logic neg);
        return neg ? (~v + 32'd1) : v;
    endfunction

endpackage

// File: rtl/ex_muldiv_if.sv
// EX-stage <-> mul/div unit signal bundle. The EX stage is the master.
// Handshake: start is a one-cycle request, accepted only when busy is low and
// flush is low; done pulses for one cycle after HI/LO have been written.
interface ex_muldiv_if;
    logic        start;
    logic [1:0]  op;
    logic [31:0] src_a;
    logic [31:0] src_b;
    logic        flush;
    logic        wr_hi;
    logic        wr_lo;
    logic [31:0] wdata;
    logic [31:0] hi;
    logic [31:0] lo;
    logic        busy;
    logic        stall;
    logic        done;
    logic        div_zero;
    logic [1:0]  dbg_state;

    modport master (
        output start, op, src_a, src_b, flush, wr_hi, wr_lo, wdata,
        input  hi, lo, busy, stall, done, div_zero, dbg_state
    );

    modport slave (
        input  start, op, src_a, src_b, flush, wr_hi, wr_lo, wdata,
        output hi, lo, busy, stall, done, div_zero, dbg_state
    );
endinterface

// File: rtl/muldiv_iter.sv
// Unsigned iterative datapath: radix-2 shift-add multiply or restoring divide,
// one bit per step, on a 64-bit accumulator {remainder/high, shift register}.
module muldiv_iter (
    input  logic        clk,
    input  logic        rst,
    input  logic        load,
    input  logic        step,
    input  logic        is_div,
    input  logic [31:0] a_mag,
    input  logic [31:0] b_mag,
    output logic [63:0] acc
);
    logic [63:0] acc_q;
    logic [31:0] b_q;
    logic [32:0] mul_sum;
    logic        take_sub;
    logic [31:0] rem_sub;
    logic [63:0] acc_next;

    always_comb begin
        mul_sum  = {1'b0, acc_q[63:32]} + (acc_q[0] ? {1'b0, b_q} : 33'd0);
        // The shifted partial remainder needs 33 bits; the difference always fits in 32.
        take_sub = acc_q[63:31] >= {1'b0, b_q};
        rem_sub  = acc_q[62:31] - b_q;
        if (is_div) begin
            acc_next = take_sub ? {rem_sub, acc_q[30:0], 1'b1} : {acc_q[62:0], 1'b0};
        end else begin
            acc_next = {mul_sum, acc_q[31:1]};
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            acc_q <= 64'd0;
            b_q   <= 32'd0;
        end else if (load) begin
            acc_q <= {32'd0, a_mag};
            b_q   <= b_mag;
        end else if (step) begin
            acc_q <= acc_next;
        end
    end

    assign acc = acc_q;
endmodule

// File: rtl/ex_muldiv.sv
// EX-stage multiply/divide unit: IDLE/RUN/FIX control, operand sign handling,
// architectural HI/LO with MTHI/MTLO, divide-by-zero flag, stall to the pipeline.
module ex_muldiv
    import ex_muldiv_pkg::*;
(
    input  logic         clk,
    input  logic         rst,
    ex_muldiv_if.slave   bus
);
    logic [1:0]  state;
    logic [4:0]  cnt;
    logic [1:0]  op_q;
    logic        a_neg;
    logic        b_neg;
    logic        b_zero;
    logic [31:0] hi_q;
    logic [31:0] lo_q;
    logic        done_q;
    logic        dz_q;

    logic        accept;
    logic        sgn_in;
    logic        a_neg_in;
    logic        b_neg_in;
    logic [31:0] a_mag_in;
    logic [31:0] b_mag_in;
    logic [63:0] acc;
    logic [63:0] prod_fix;
    logic [31:0] hi_fix;
    logic [31:0] lo_fix;

    assign accept   = (state == ST_IDLE) && bus.start && !bus.flush;
    assign sgn_in   = is_signed_op(bus.op);
    assign a_neg_in = sgn_in & bus.src_a[31];
    assign b_neg_in = sgn_in & bus.src_b[31];
    assign a_mag_in = mag32(bus.src_a, a_neg_in);
    assign b_mag_in = mag32(bus.src_b, b_neg_in);

    muldiv_iter u_iter (
        .clk    (clk),
        .rst    (rst),
        .load   (accept),
        .step   (state == ST_RUN),
        .is_div (is_div_op(op_q)),
        .a_mag  (a_mag_in),
        .b_mag  (b_mag_in),
        .acc    (acc)
    );

    // Quotient sign follows the operand signs; remainder follows the dividend.
    always_comb begin
        prod_fix = (a_neg ^ b_neg) ? (~acc + 64'd1) : acc;
        if (is_div_op(op_q)) begin
            hi_fix = mag32(acc[63:32], a_neg);
            lo_fix = b_zero ? 32'hFFFF_FFFF : mag32(acc[31:0], a_neg ^ b_neg);
        end else begin
            hi_fix = prod_fix[63:32];
            lo_fix = prod_fix[31:0];
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state  <= ST_IDLE;
            cnt    <= 5'd0;
            op_q   <= 2'b00;
            a_neg  <= 1'b0;
            b_neg  <= 1'b0;
            b_zero <= 1'b0;
            hi_q   <= 32'd0;
            lo_q   <= 32'd0;
            done_q <= 1'b0;
            dz_q   <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (bus.wr_hi) hi_q <= bus.wdata;
                    if (bus.wr_lo) lo_q <= bus.wdata;
                    if (accept) begin
                        state  <= ST_RUN;
                        cnt    <= 5'd0;
                        op_q   <= bus.op;
                        a_neg  <= a_neg_in;
                        b_neg  <= b_neg_in;
                        b_zero <= (bus.src_b == 32'd0);
                        dz_q   <= 1'b0;
                    end
                end
                ST_RUN: begin
                    if (bus.flush) begin
                        state <= ST_IDLE;
                    end else begin
                        cnt <= cnt + 5'd1;
                        if (cnt == 5'(MULDIV_ITERS - 1)) state <= ST_FIX;
                    end
                end
                ST_FIX: begin
                    state <= ST_IDLE;
                    if (!bus.flush) begin
                        hi_q   <= hi_fix;
                        lo_q   <= lo_fix;
                        done_q <= 1'b1;
                        dz_q   <= is_div_op(op_q) & b_zero;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    assign bus.hi        = hi_q;
    assign bus.lo        = lo_q;
    assign bus.busy      = (state != ST_IDLE);
    assign bus.stall     = (state != ST_IDLE);
    assign bus.done      = done_q;
    assign bus.div_zero  = dz_q;
    assign bus.dbg_state = state;
endmodule

// File: tb/tb_ex_muldiv.sv
// Bench for ex_muldiv: a cycle-level behavioural model built on plain
// arithmetic, a per-cycle output compare, directed cases and random traffic.
module tb_ex_muldiv;
    import ex_muldiv_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b0;
    int   checks = 0;
    int   errors = 0;

    ex_muldiv_if bus ();

    ex_muldiv dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    // ---------------- reference model ----------------
    function automatic logic [63:0] ref_result(input logic [1:0] op, input logic [31:0] a,
                                               input logic [31:0] b);
        longint sa, sb, q, r;
        logic [63:0] p;
        p = 64'd0;
        case (op)
            OP_MULT: begin
                sa = longint'($signed(a));
                sb = longint'($signed(b));
                p  = 64'(sa * sb);
            end
            OP_MULTU: p = {32'd0, a} * {32'd0, b};
            default: begin
                if (op == OP_DIV) begin
                    sa = longint'($signed(a));
                    sb = longint'($signed(b));
                end else begin
                    sa = longint'({32'd0, a});
                    sb = longint'({32'd0, b});
                end
                if (b == 32'd0) begin
                    p = {a, 32'hFFFF_FFFF};
                end else begin
                    q = sa / sb;
                    r = sa % sb;
                    p = {r[31:0], q[31:0]};
                end
            end
        endcase
        return p;
    endfunction

    int          m_left = 0;
    logic [31:0] m_hi = '0, m_lo = '0;
    logic        m_done = 1'b0, m_dz = 1'b0;
    logic [63:0] pend = '0;
    logic        pend_dz = 1'b0;

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            m_left = 0; m_hi = '0; m_lo = '0; m_done = 1'b0; m_dz = 1'b0;
        end else begin
            m_done = 1'b0;
            if (m_left == 0) begin
                if (bus.wr_hi) m_hi = bus.wdata;
                if (bus.wr_lo) m_lo = bus.wdata;
                if (bus.start && !bus.flush) begin
                    m_left  = MULDIV_ITERS + 1;
                    pend    = ref_result(bus.op, bus.src_a, bus.src_b);
                    pend_dz = bus.op[1] && (bus.src_b == 32'd0);
                    m_dz    = 1'b0;
                end
            end else if (bus.flush) begin
                m_left = 0;
            end else begin
                m_left--;
                if (m_left == 0) begin
                    {m_hi, m_lo} = pend;
                    m_done = 1'b1;
                    m_dz   = pend_dz;
                end
            end
        end
    end

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // ---------------- per-cycle compare ----------------
    always @(posedge clk) begin
        #1;
        check("cycle {hi,lo,busy,stall,done,dz}",
              {bus.hi, bus.lo, bus.busy, bus.stall, bus.done, bus.div_zero},
              {m_hi, m_lo, m_left != 0, m_left != 0, m_done, m_dz});
    end

    // ---------------- driver tasks ----------------
    task automatic run_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                          output int lat);
        @(negedge clk);
        bus.start = 1'b1; bus.op = op; bus.src_a = a; bus.src_b = b;
        lat = 0;
        do begin
            @(posedge clk); #1;
            bus.start = 1'b0;
            lat++;
        end while (!bus.done && lat < 100);
    endtask

    task automatic directed(input string name, input logic [1:0] op, input logic [31:0] a,
                            input logic [31:0] b, input logic [31:0] hi_e, input logic [31:0] lo_e,
                            input logic dz_e);
        int lat;
        run_op(op, a, b, lat);
        check({name, " latency"}, lat, 34);
        check({name, " hi"}, bus.hi, hi_e);
        check({name, " lo"}, bus.lo, lo_e);
        check({name, " div_zero"}, bus.div_zero, dz_e);
    endtask

    task automatic drain();
        int n = 0;
        while (m_left != 0 && n < 60) begin
            @(posedge clk); #1; n++;
        end
        check("drain within bound", n < 60, 1'b1);
    endtask

    initial begin
        int  saw_done;
        int  busy_cnt;
        int  lat;
        bus.start = 0; bus.op = 0; bus.src_a = 0; bus.src_b = 0; bus.flush = 0;
        bus.wr_hi = 0; bus.wr_lo = 0; bus.wdata = 0;
        repeat (3) @(posedge clk);
        @(negedge clk) rst = 1'b1;
        @(posedge clk); #1;
        check("reset outputs", {bus.hi, bus.lo, bus.busy, bus.stall, bus.done, bus.div_zero}, '0);

        // MULTU all-ones: busy exactly 33 cycles, done in the 34th
        @(negedge clk);
        bus.start = 1; bus.op = OP_MULTU; bus.src_a = 32'hFFFF_FFFF; bus.src_b = 32'hFFFF_FFFF;
        lat = 0; busy_cnt = 0;
        do begin
            @(posedge clk); #1;
            bus.start = 0; lat++;
            if (bus.busy) busy_cnt++;
        end while (!bus.done && lat < 100);
        check("multu latency", lat, 34);
        check("multu busy cycles", busy_cnt, 33);
        check("multu hi", bus.hi, 32'hFFFF_FFFE);
        check("multu lo", bus.lo, 32'h0000_0001);

        directed("mult -7*3", OP_MULT, 32'hFFFF_FFF9, 32'd3, 32'hFFFF_FFFF, 32'hFFFF_FFEB, 1'b0);
        directed("div -7/2", OP_DIV, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0);
        directed("divu 100/0", OP_DIVU, 32'd100, 32'd0, 32'd100, 32'hFFFF_FFFF, 1'b1);
        directed("divu 9/4", OP_DIVU, 32'd9, 32'd4, 32'd1, 32'd2, 1'b0);
        directed("div min/-1", OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 32'h8000_0000, 1'b0);
        directed("div -9/0", OP_DIV, 32'hFFFF_FFF7, 32'd0, 32'hFFFF_FFF7, 32'hFFFF_FFFF, 1'b1);

        // Preload, then flush mid-run
        @(negedge clk); bus.wr_hi = 1; bus.wdata = 32'hAAAA_0000;
        @(negedge clk); bus.wr_hi = 0; bus.wr_lo = 1; bus.wdata = 32'h0000_5555;
        @(negedge clk); bus.wr_lo = 0;
        bus.start = 1; bus.op = OP_MULTU; bus.src_a = 32'd3; bus.src_b = 32'd4;
        @(posedge clk); #1 bus.start = 0;
        repeat (9) @(posedge clk);
        #1 bus.flush = 1;
        @(posedge clk); #1 bus.flush = 0;
        check("flush busy", bus.busy, 1'b0);
        saw_done = 0;
        repeat (40) begin
            @(posedge clk); #1;
            if (bus.done) saw_done++;
        end
        check("flush no done", saw_done, 0);
        check("flush hi kept", bus.hi, 32'hAAAA_0000);
        check("flush lo kept", bus.lo, 32'h0000_5555);

        // Reset mid-run
        @(negedge clk);
        bus.start = 1; bus.op = OP_MULTU; bus.src_a = 32'd3; bus.src_b = 32'd4;
        @(posedge clk); #1 bus.start = 0;
        repeat (19) @(posedge clk);
        #1 rst = 1'b0;
        #1 check("async reset outputs",
                 {bus.hi, bus.lo, bus.busy, bus.stall, bus.done, bus.div_zero}, '0);
        @(negedge clk) rst = 1'b1;

        // start together with flush is refused
        @(negedge clk);
        bus.start = 1; bus.flush = 1; bus.op = OP_MULTU; bus.src_a = 32'd5; bus.src_b = 32'd6;
        @(posedge clk); #1 bus.start = 0; bus.flush = 0;
        check("start+flush refused", bus.busy, 1'b0);
        directed("mult after reset", OP_MULT, 32'd5, 32'hFFFF_FFFE, 32'hFFFF_FFFF, 32'hFFFF_FFF6, 1'b0);

        // Random traffic: ops, stray starts while busy, MTHI/MTLO, occasional flush
        for (int i = 0; i < 50; i++) begin
            for (int c = 0; c < 38; c++) begin
                @(negedge clk);
                bus.start = (c == 0) || ($urandom_range(0, 9) == 0);
                bus.op    = 2'($urandom_range(0, 3));
                case ($urandom_range(0, 5))
                    0: bus.src_a = 32'h8000_0000;
                    1: bus.src_a = 32'($urandom_range(0, 20));
                    default: bus.src_a = $urandom;
                endcase
                case ($urandom_range(0, 7))
                    0: bus.src_b = 32'd0;
                    1: bus.src_b = 32'hFFFF_FFFF;
                    2: bus.src_b = 32'($urandom_range(1, 9));
                    default: bus.src_b = $urandom;
                endcase
                bus.flush = ($urandom_range(0, 79) == 0);
                bus.wr_hi = ($urandom_range(0, 7) == 0);
                bus.wr_lo = ($urandom_range(0, 7) == 0);
                bus.wdata = $urandom;
            end
            @(negedge clk);
            bus.start = 0; bus.flush = 0; bus.wr_hi = 0; bus.wr_lo = 0;
            drain();
        end

        repeat (3) @(posedge clk);
        #2;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/ex_muldiv.md
EX_MULDIV -- requirements
Module: ex_muldiv

Interface
REQ-001 clk  input  1  rising-edge clock for all state.
REQ-002 rst  input  1  asynchronous, active-low reset; asserted when 0.
REQ-003 start  input  1  one-cycle request from the EX stage; the ID/EX register holds a mult/div op.
REQ-004 op  input  2  operation: 00 MULT, 01 MULTU, 10 DIV, 11 DIVU.
REQ-005 src_a  input  32  multiplicand or dividend, already forwarded from the ID/EX rs_data path.
REQ-006 src_b  input  32  multiplier or divisor, already forwarded from the ID/EX rt_data path.
REQ-007 flush  input  1  cancel any in-flight op; same flush that zeroes ID/EX control.
REQ-008 wr_hi, wr_lo  input  1 each  MTHI/MTLO write enables.
REQ-009 wdata  input  32  MTHI/MTLO data.
REQ-010 hi, lo  output  32 each  architectural HI/LO registers.
REQ-011 busy  output  1  high while an op is in flight.
REQ-012 stall  output  1  equals busy; freezes PC, IF/ID and ID/EX, and holds the EX instruction.
REQ-013 done  output  1  one-cycle pulse in the cycle after HI/LO update.
REQ-014 div_zero  output  1  sticky flag, set by DIV/DIVU with src_b==0, cleared by the next accepted start.

Function
REQ-015 The FSM SHALL have states IDLE, RUN and FIX; busy SHALL be 1 in RUN and FIX.
REQ-016 start in IDLE SHALL latch op, |src_a|, |src_b| and the operand signs, clear the iteration counter, and enter RUN.
- Magnitudes are taken for signed ops only.
REQ-017 start in RUN or FIX SHALL be ignored.
REQ-018 RUN SHALL perform exactly 32 iterations, one per cycle, then enter FIX.
- MULT/MULTU: radix-2 shift-add into a 64-bit product.
- DIV/DIVU: restoring, one quotient bit per cycle.
REQ-019 FIX SHALL apply the sign correction, write HI/LO, and return to IDLE in one cycle.
- Signed product is negated if the signs differ.
- Quotient is negative if the signs differ; remainder takes the dividend's sign.
REQ-020 Latency SHALL be 34 edges: accept at edge T0, HI/LO written at edge T33, done high for the cycle after T33, busy low after T33.
REQ-021 Multiply result: HI = product[63:32], LO = product[31:0].
REQ-022 Divide result: LO = quotient, HI = remainder.
REQ-023 Divide by zero SHALL run the full latency and yield LO=32'hFFFFFFFF, HI=src_a for both DIV and DIVU, and set div_zero.
REQ-024 DIV 32'h80000000 / 32'hFFFFFFFF SHALL yield LO=32'h80000000, HI=0 (wraps, no trap).
REQ-025 flush SHALL return the FSM to IDLE on the next edge from any state, including FIX.
- HI/LO are left unchanged, no done pulse is produced, and busy drops after that edge.
REQ-026 flush and start in the same cycle: flush SHALL win and the op SHALL NOT be accepted.
REQ-027 wr_hi/wr_lo SHALL update HI/LO on the edge only in IDLE and are ignored otherwise.
- If asserted together with start, the write SHALL be applied and is later overwritten at FIX.
REQ-028 hi/lo SHALL hold their old values throughout RUN.
- MFHI/MFLO hazards are covered because stall holds dependent instructions.

Reset
REQ-029 rst=0 SHALL asynchronously force:
- state IDLE, counter 0;
- hi=0, lo=0;
- busy=0, stall=0, done=0, div_zero=0;
- all internal operand/partial registers 0.
REQ-030 Reset mid-operation SHALL abandon the op with no done pulse.
- The first start accepted after rst returns to 1 SHALL behave per REQ-016.

Structure
REQ-031 The shared package SHALL hold:
- the op encodings (OP_MULT=2'b00, OP_MULTU=2'b01, OP_DIV=2'b10, OP_DIVU=2'b11);
- the FSM state encoding;
- the constant MULDIV_ITERS=32.
REQ-032 The iterative datapath SHALL be one sub-module, muldiv_iter: 64-bit accumulator/remainder, shift register, one-step add/subtract.
- ex_muldiv owns the FSM, sign handling and HI/LO.

Verification
REQ-033 MULTU src_a=32'hFFFFFFFF, src_b=32'hFFFFFFFF:
- done at cycle 34; HI=32'hFFFFFFFE, LO=32'h00000001; busy high for cycles 1..33.
REQ-034 MULT src_a=-7 (32'hFFFFFFF9), src_b=3:
- HI=32'hFFFFFFFF, LO=32'hFFFFFFEB.
REQ-035 DIV src_a=-7, src_b=2:
- LO=32'hFFFFFFFD (-3), HI=32'hFFFFFFFF (-1).
REQ-036 DIVU src_a=100, src_b=0:
- LO=32'hFFFFFFFF, HI=100, div_zero=1.
- A following DIVU 9/4 clears div_zero and gives LO=2, HI=1.
REQ-037 Preload with MTHI=32'hAAAA0000, MTLO=32'h5555; start MULTU 3*4; assert flush at cycle 10:
- busy low from cycle 11, no done, HI/LO stay at the preloaded values.
- Repeat with rst=0 at cycle 20 instead: all outputs 0 at once.
- Then start with flush in the same cycle: start is not accepted.
